// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcode/funct
// constants, ALU and mux-select encodings, FSM states and instruction classes.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] REGDST_RD  = 2'd0;
    localparam logic [1:0] REGDST_RT  = 2'd1;
    localparam logic [1:0] REGDST_R31 = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam logic [1:0] PCSEL_JUMP = 2'd0;
    localparam logic [1:0] PCSEL_ALU  = 2'd1;
    localparam logic [1:0] PCSEL_RS   = 2'd2;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, MEM_WB, ALU_WB, HALT
    } state_e;

    typedef enum logic [3:0] {
        IC_RTYPE, IC_ITYPE_ALU, IC_LOAD, IC_STORE, IC_BRANCH,
        IC_JUMP, IC_JAL, IC_JR, IC_ILLEGAL
    } iclass_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
//   Op, funct : IR opcode and function fields
//   iclass    : instruction class (illegal for unlisted Op / R-type funct)
//   alu_ctrl  : ALU operation the EXEC state should request
module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] Op,
    input  logic [5:0] funct,
    output iclass_e    iclass,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        iclass   = IC_ILLEGAL;
        alu_ctrl = ALU_ADD;
        case (Op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin iclass = IC_RTYPE; alu_ctrl = ALU_ADD; end
                    FN_SUB: begin iclass = IC_RTYPE; alu_ctrl = ALU_SUB; end
                    FN_SLT: begin iclass = IC_RTYPE; alu_ctrl = ALU_SLT; end
                    FN_JR:  iclass = IC_JR;
                    default: iclass = IC_ILLEGAL;
                endcase
            end
            OP_J:    iclass = IC_JUMP;
            OP_JAL:  iclass = IC_JAL;
            OP_BNE:  begin iclass = IC_BRANCH;    alu_ctrl = ALU_SUB; end
            OP_ADDI: begin iclass = IC_ITYPE_ALU; alu_ctrl = ALU_ADD; end
            OP_XORI: begin iclass = IC_ITYPE_ALU; alu_ctrl = ALU_XOR; end
            OP_LW:   iclass = IC_LOAD;
            OP_SW:   iclass = IC_STORE;
            default: iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/
// writeback, handshakes with the shared memory port, halts on illegal
// opcodes or memory timeout (exit only through reset).
//   clk, reset (sync, active-high); Op, funct, zero, mem_ready inputs
//   mem_req, IorD, MemWr, IRWr, PCWr, RegWr, ALUSrcA, ALUSrcB, ALUCtrl,
//   RegDst, MemToReg, PCSel, AddSel : datapath strobes and selects
//   halted : fault indication
//   cycle_count, instr_count : performance counters when PERF_CNT_EN is
//   defined, otherwise tied to 0
module multicycle_controller
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 15,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           Op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 IorD,
    output logic                 MemWr,
    output logic                 IRWr,
    output logic                 PCWr,
    output logic                 RegWr,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ALUCtrl,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemToReg,
    output logic [1:0]           PCSel,
    output logic                 AddSel,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_e            state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    iclass_e           iclass;
    logic [2:0]        dec_alu_ctrl;

    mc_decode u_decode (
        .Op       (Op),
        .funct    (funct),
        .iclass   (iclass),
        .alu_ctrl (dec_alu_ctrl)
    );

    // This is the MAX_WAIT-th consecutive cycle without mem_ready.
    assign timeout = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // Wait counter: clears on every state change, counts cycles stalled in FETCH/MEM
    always_ff @(posedge clk) begin
        if (reset || (next_state != state))
            wait_cnt <= '0;
        else if ((state == FETCH) || (state == MEM))
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Next-state and outputs; reset forces every output low
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWr      = 1'b0;
        IRWr       = 1'b0;
        PCWr       = 1'b0;
        RegWr      = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RT;
        ALUCtrl    = ALU_ADD;
        RegDst     = REGDST_RD;
        MemToReg   = M2R_ALU;
        PCSel      = PCSEL_JUMP;
        AddSel     = 1'b0;
        halted     = 1'b0;
        if (reset) begin
            next_state = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    PCSel   = PCSEL_ALU;
                    if (mem_ready) begin
                        IRWr       = 1'b1;
                        PCWr       = 1'b1;
                        next_state = DECODE;
                    end else if (timeout) begin
                        next_state = HALT;
                    end
                end
                DECODE: begin
                    ALUSrcB = SRCB_IMM_SH;
                    case (iclass)
                        IC_JUMP: begin
                            PCWr       = 1'b1;
                            next_state = FETCH;
                        end
                        IC_JAL: begin
                            PCWr       = 1'b1;
                            RegWr      = 1'b1;
                            RegDst     = REGDST_R31;
                            MemToReg   = M2R_PC;
                            next_state = FETCH;
                        end
                        IC_JR: begin
                            PCWr       = 1'b1;
                            PCSel      = PCSEL_RS;
                            next_state = FETCH;
                        end
                        IC_ILLEGAL: next_state = HALT;
                        default:    next_state = EXEC;
                    endcase
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUCtrl = dec_alu_ctrl;
                    case (iclass)
                        IC_RTYPE: begin
                            ALUSrcB    = SRCB_RT;
                            next_state = ALU_WB;
                        end
                        IC_ITYPE_ALU: begin
                            ALUSrcB    = SRCB_IMM;
                            next_state = ALU_WB;
                        end
                        IC_LOAD, IC_STORE: begin
                            ALUSrcB    = SRCB_IMM;
                            next_state = MEM;
                        end
                        IC_BRANCH: begin
                            // Branch taken when operands differ; target already in ALUOut.
                            ALUSrcB    = SRCB_RT;
                            AddSel     = 1'b1;
                            PCSel      = PCSEL_ALU;
                            PCWr       = ~zero;
                            next_state = FETCH;
                        end
                        default: next_state = HALT;
                    endcase
                end
                MEM: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    MemWr   = (iclass == IC_STORE);
                    if (mem_ready)
                        next_state = (iclass == IC_STORE) ? FETCH : MEM_WB;
                    else if (timeout)
                        next_state = HALT;
                end
                MEM_WB: begin
                    RegWr      = 1'b1;
                    RegDst     = REGDST_RT;
                    MemToReg   = M2R_MEM;
                    next_state = FETCH;
                end
                ALU_WB: begin
                    RegWr      = 1'b1;
                    RegDst     = (iclass == IC_RTYPE) ? REGDST_RD : REGDST_RT;
                    next_state = FETCH;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: next_state = HALT;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [CNT_WIDTH-1:0] instr_cnt;

    // Performance counters; an instruction retires on each entry into FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != HALT)
                cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if ((next_state == FETCH) && (state != FETCH))
                instr_cnt <= instr_cnt + CNT_WIDTH'(1);
        end
    end

    assign cycle_count = cycle_cnt;
    assign instr_count = instr_cnt;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller. Each instruction
// is expanded into its expected per-cycle output trace from the instruction's
// documented sequencing, then replayed against the DUT.
module tb_multicycle_controller;

    localparam int unsigned MAXW = 15;
    localparam int unsigned CW   = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    Op, funct;
    logic          zero, mem_ready;
    logic          mem_req, IorD, MemWr, IRWr, PCWr, RegWr, ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic [2:0]    ALUCtrl;
    logic [1:0]    RegDst, MemToReg, PCSel;
    logic          AddSel, halted;
    logic [CW-1:0] cycle_count, instr_count;

    always #5 clk = ~clk;

    multicycle_controller #(.MAX_WAIT(MAXW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .Op(Op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWr(MemWr),
        .IRWr(IRWr), .PCWr(PCWr), .RegWr(RegWr), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .RegDst(RegDst),
        .MemToReg(MemToReg), .PCSel(PCSel), .AddSel(AddSel), .halted(halted),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    typedef struct packed {
        logic       mem_req, iord, memwr, irwr, pcwr, regwr, srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic [1:0] regdst, m2r, pcsel;
        logic       addsel, halted;
    } outs_t;

    typedef struct {
        bit         rst;
        logic [5:0] op, fn;
        logic       z, mr;
        outs_t      exp;
        bit         fin;
    } step_t;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BNE = 4,
                   K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

    step_t q[$];
    int    n_vec = 0;
    int    n_err = 0;
    outs_t obs;

    assign obs = {mem_req, IorD, MemWr, IRWr, PCWr, RegWr, ALUSrcA, ALUSrcB,
                  ALUCtrl, RegDst, MemToReg, PCSel, AddSel, halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a) return K_R;
                if (fn == 6'h08) return K_JR;
                return K_ILL;
            end
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h05: return K_BNE;
            6'h08, 6'h0e: return K_I;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    task automatic push(input bit rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic mr, input outs_t e, input bit fin);
        step_t s;
        s.rst = rst; s.op = op; s.fn = fn; s.z = z; s.mr = mr; s.exp = e; s.fin = fin;
        q.push_back(s);
    endtask

    // Twenty cycles parked in HALT with arbitrary inputs, then a reset.
    task automatic halt_tail();
        outs_t h;
        h = '0;
        h.halted = 1'b1;
        for (int i = 0; i < 20; i++) push(1'b0, r6(), r6(), rb(), rb(), h, 1'b0);
        push(1'b1, r6(), r6(), rb(), rb(), '0, 1'b0);
    endtask

    // Expected trace of one instruction: fd fetch stalls, md memory stalls.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fd,
                         input int md, input logic zx, output bit faulted);
        outs_t o;
        int    k;
        k = kind_of(op, fn);
        faulted = 1'b0;
        o = '0; o.mem_req = 1'b1; o.srcb = 2'd1; o.pcsel = 2'd1;
        for (int i = 0; i < fd && i < int'(MAXW); i++) push(1'b0, r6(), r6(), rb(), 1'b0, o, 1'b0);
        if (fd >= int'(MAXW)) begin faulted = 1'b1; halt_tail(); return; end
        o.irwr = 1'b1; o.pcwr = 1'b1;
        push(1'b0, r6(), r6(), rb(), 1'b1, o, 1'b0);

        o = '0; o.srcb = 2'd3;
        case (k)
            K_J:   begin o.pcwr = 1'b1; push(1'b0, op, fn, rb(), rb(), o, 1'b1); return; end
            K_JAL: begin
                o.pcwr = 1'b1; o.regwr = 1'b1; o.regdst = 2'd2; o.m2r = 2'd2;
                push(1'b0, op, fn, rb(), rb(), o, 1'b1); return;
            end
            K_JR:  begin o.pcwr = 1'b1; o.pcsel = 2'd2; push(1'b0, op, fn, rb(), rb(), o, 1'b1); return; end
            K_ILL: begin push(1'b0, op, fn, rb(), rb(), o, 1'b0); faulted = 1'b1; halt_tail(); return; end
            default: push(1'b0, op, fn, rb(), rb(), o, 1'b0);
        endcase

        o = '0; o.srca = 1'b1;
        case (k)
            K_R, K_I: begin
                o.srcb = (k == K_R) ? 2'd0 : 2'd2;
                if (k == K_R) o.alu = (fn == 6'h22) ? 3'd1 : (fn == 6'h2a) ? 3'd4 : 3'd0;
                else          o.alu = (op == 6'h0e) ? 3'd2 : 3'd0;
                push(1'b0, op, fn, rb(), rb(), o, 1'b0);
                o = '0; o.regwr = 1'b1; o.regdst = (k == K_R) ? 2'd0 : 2'd1;
                push(1'b0, op, fn, rb(), rb(), o, 1'b1);
            end
            K_BNE: begin
                o.alu = 3'd1; o.addsel = 1'b1; o.pcsel = 2'd1; o.pcwr = ~zx;
                push(1'b0, op, fn, zx, rb(), o, 1'b1);
            end
            default: begin
                o.srcb = 2'd2;
                push(1'b0, op, fn, rb(), rb(), o, 1'b0);
                o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.memwr = (k == K_SW);
                for (int i = 0; i < md && i < int'(MAXW); i++) push(1'b0, op, fn, rb(), 1'b0, o, 1'b0);
                if (md >= int'(MAXW)) begin faulted = 1'b1; halt_tail(); return; end
                push(1'b0, op, fn, rb(), 1'b1, o, k == K_SW);
                if (k == K_LW) begin
                    o = '0; o.regwr = 1'b1; o.regdst = 2'd1; o.m2r = 2'd1;
                    push(1'b0, op, fn, rb(), rb(), o, 1'b1);
                end
            end
        endcase
    endtask

    task automatic rst_step();
        push(1'b1, r6(), r6(), rb(), rb(), '0, 1'b0);
    endtask

    logic [5:0] legal_ops [8];
    logic [5:0] r_fns [4];

    initial begin
        bit            f;
        int unsigned   m_cyc, m_ins;
        bit            known;
        logic [5:0]    op, fn;
        int            fd, md, start, len;

        legal_ops = '{6'h00, 6'h02, 6'h03, 6'h05, 6'h08, 6'h0e, 6'h23, 6'h2b};
        r_fns     = '{6'h20, 6'h22, 6'h2a, 6'h08};

        // Directed scenarios
        rst_step(); rst_step();
        build(6'h00, 6'h20, 0, 0, 1'b0, f);   // ADD
        build(6'h23, 6'h00, 0, 3, 1'b0, f);   // LW, memory late by 3 cycles
        build(6'h05, 6'h00, 0, 0, 1'b0, f);   // BNE taken
        build(6'h05, 6'h00, 0, 0, 1'b1, f);   // BNE not taken
        build(6'h03, 6'h00, 0, 0, 1'b0, f);   // JAL
        build(6'h2b, 6'h00, 1, 2, 1'b0, f);   // SW with stalls
        build(6'h3f, 6'h00, 0, 0, 1'b0, f);   // illegal opcode
        build(6'h00, 6'h20, int'(MAXW), 0, 1'b0, f);  // fetch timeout
        build(6'h08, 6'h00, 0, 0, 1'b0, f);   // three ADDIs from reset
        build(6'h08, 6'h00, 0, 0, 1'b0, f);
        build(6'h08, 6'h00, 0, 0, 1'b0, f);
        build(6'h23, 6'h00, 0, int'(MAXW), 1'b0, f);  // memory timeout

        // Random mix
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 19) == 0) op = r6();
            else op = legal_ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 19) == 0) fn = r6();
            else fn = r_fns[$urandom_range(0, 3)];
            fd = ($urandom_range(0, 39) == 0) ? int'(MAXW) : int'($urandom_range(0, 2));
            md = ($urandom_range(0, 39) == 0) ? int'(MAXW) : int'($urandom_range(0, 3));
            start = q.size();
            build(op, fn, fd, md, rb(), f);
            len = q.size() - start;
            if (!f && len > 1 && $urandom_range(0, 11) == 0) begin
                // Abort the instruction part-way through with a reset.
                for (int i = 0; i < int'($urandom_range(1, len - 1)); i++) void'(q.pop_back());
                rst_step();
            end
        end

        m_cyc = 0; m_ins = 0; known = 1'b0;
        reset = 1'b1; Op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        foreach (q[i]) begin
            @(negedge clk);
            reset = q[i].rst; Op = q[i].op; funct = q[i].fn;
            zero = q[i].z; mem_ready = q[i].mr;
            #1;
            check($sformatf("outs step %0d", i), 32'(obs), 32'(q[i].exp));
            if (known) begin
`ifdef PERF_CNT_EN
                check($sformatf("cycle_count step %0d", i), cycle_count, m_cyc);
                check($sformatf("instr_count step %0d", i), instr_count, m_ins);
`else
                check($sformatf("cycle_count step %0d", i), cycle_count, 32'd0);
                check($sformatf("instr_count step %0d", i), instr_count, 32'd0);
`endif
            end
            if (q[i].rst) begin
                m_cyc = 0; m_ins = 0; known = 1'b1;
            end else begin
                if (!q[i].exp.halted) m_cyc++;
                if (q[i].fin) m_ins++;
            end
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
